nano_cpu: RTL and testbench
===========================

# nano_cpu

Multi-cycle 16-bit accumulator-free load/store processor (NanoCPU) with four 16-bit general registers and an 8-bit program counter. It connects to a single unified 256 x 16 instruction/data memory that has a combinational read and a synchronous write. It fetches, decodes and executes one instruction every three clock cycles until it reaches END.

## Interface
- No parameters.
- ck  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- address  output  8  memory address (PC on fetch, IR[11:4] on LD/ST)
- dataR  input  16  memory read data, combinational from address
- dataW  output  16  memory write data
- ce  output  1  memory access enable
- we  output  1  memory write enable, memory writes dataW at address on rising ck

## Operation
- Instruction: op = IR[15:12]. Register fields use bits [1:0] of each nibble; bits [3:2] are ignored.
- Memory-format instructions: addr = IR[11:4], r = IR[3:0].
- ALU-format instructions: rd = IR[11:8], rs1 = IR[7:4], rs2 = IR[3:0].
- 0 LD: R[r] <- mem[addr].
- 1 ST: mem[addr] <- R[r].
- 2 JMP: PC <- addr.
- 3 BRNZ: PC <- addr if R[r] != 0; otherwise no effect.
- 4 XOR: R[rd] <- R[rs1] ^ R[rs2].
- 5 SUB: R[rd] <- R[rs1] - R[rs2], mod 2^16.
- 6 ADD: R[rd] <- R[rs1] + R[rs2], mod 2^16.
- 7 LESS: R[rd] <- 16'h0001 if R[rs1] < R[rs2] (unsigned), else 16'h0000.
- 8 INC: R[rd] <- R[rs1] + 1, mod 2^16.
- 9 DEC: R[rd] <- R[rs1] - 1, mod 2^16.
- F END: enter HALT.
- A–E: NOP.
- No flags. Registers are written only in EXECUTE.

## Timing
- FSM states: FETCH -> DECODE -> EXECUTE -> FETCH; EXECUTE of END -> HALT. HALT is left only by reset.
- FETCH: address = PC, ce = 1, we = 0. On the clock edge, IR <- dataR and PC <- PC + 1. PC wraps 255 -> 0.
- DECODE: for LD/ST, address = IR[11:4] and ce = 1. Otherwise address = PC and ce = 0. we = 0.
- EXECUTE:
  - LD: address = IR[11:4], ce = 1, R[r] <- dataR at the clock edge.
  - ST: address = IR[11:4], ce = 1, we = 1, dataW = R[r] for exactly this one cycle.
  - JMP / taken BRNZ: PC <- addr at the clock edge.
  - ALU ops: write rd at the clock edge.
- dataW = 0 whenever ST is not in EXECUTE.
- Each instruction takes 3 cycles. The first fetch occurs in the first cycle after rst deasserts.
- Reset (asynchronous, any time): PC = 0, IR = 0, R0–R3 = 0, state = FETCH, address = 0, dataW = 0, ce = 0, we = 0. A reset mid-instruction aborts it with no partial register write.
- HALT: address = PC, ce = 0, we = 0, dataW = 0. Registers and PC are frozen.
- Write-after-read within an instruction is well defined: operands are sampled before writeback. Example: ADD R0, R0, R3 uses the old R0.

## Configuration
- NANO_CPU_INCDEC_EN defined: opcodes 8 (INC) and 9 (DEC) execute as specified.
- NANO_CPU_INCDEC_EN undefined: opcodes 8 and 9 are NOPs (no register write, PC += 1 only) and the incrementer/decrementer logic is omitted.

## Test plan
- Reset: hold rst = 0 mid-run -> all outputs 0, PC = 0. Release -> address = 0 and ce = 1 in the next cycle.
- Load/ALU sequence:
  - Stimulus: mem[0..3] = 01E0, 01F1, 0202, 0213; mem[30..33] = 1111, 2222, 3333, 4444; then 6003, 5101, 4300, 7210.
  - Required: R0 = 5555, R1 = 3333, R2 = 0001, R3 = 0000.
- Store: continuing with 10F0, 1101, 1112 -> mem[15] = 5555, mem[16] = 3333, mem[17] = 0001. we is high for exactly one cycle per ST.
- Branch/jump:
  - Stimulus: 3FF2 with R2 = 1 -> next fetch at address FF. mem[FF] = 2140 -> next fetch at 14.
  - With R2 = 0, 3FF2 falls through to PC + 1.
- INC/DEC/END with the macro defined:
  - Stimulus: mem[20..24] = 8000, 8110, 9220, 9330, F000.
  - Required: R0 = 5556, R1 = 3334, R2 = 0000, R3 = FFFF. The CPU halts, then ce stays 0 and registers stay frozen for 20 cycles.
- Wrap/undefined: A123 at PC = 0 -> no state change except PC. Execution at address FF with a non-jump instruction -> next fetch at address 00. Without the macro, 8000 leaves R0 unchanged.

Source files
------------

// File: rtl/nano_cpu.sv
// nano_cpu: multi-cycle 16-bit load/store CPU, FETCH/DECODE/EXECUTE per instruction.
// Optional INC/DEC opcodes enabled by defining NANO_CPU_INCDEC_EN.
module nano_cpu (
    input  logic        ck,
    input  logic        rst,
    output logic [7:0]  address,
    input  logic [15:0] dataR,
    output logic [15:0] dataW,
    output logic        ce,
    output logic        we
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t           state, state_nx;
    logic [7:0]       pc;
    logic [15:0]      ir;
    logic [3:0][15:0] rf;

    logic [3:0]  op;
    logic [7:0]  addr;
    logic [1:0]  rn, rd, rs1, rs2;
    logic [15:0] a, b;
    logic        unused;

    logic is_ld, is_st, is_jmp, is_brnz, is_end;
    logic is_xor, is_sub, is_add, is_less;
`ifdef NANO_CPU_INCDEC_EN
    logic is_inc, is_dec;
`endif

    logic        rf_we;
    logic [1:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        pc_ld;

    assign op     = ir[15:12];
    assign addr   = ir[11:4];
    assign rn     = ir[1:0];
    assign rd     = ir[9:8];
    assign rs1    = ir[5:4];
    assign rs2    = ir[1:0];
    assign unused = ^ir[3:2];
    assign a      = rf[rs1];
    assign b      = rf[rs2];

    assign is_ld   = (op == 4'h0);
    assign is_st   = (op == 4'h1);
    assign is_jmp  = (op == 4'h2);
    assign is_brnz = (op == 4'h3);
    assign is_xor  = (op == 4'h4);
    assign is_sub  = (op == 4'h5);
    assign is_add  = (op == 4'h6);
    assign is_less = (op == 4'h7);
    assign is_end  = (op == 4'hF);
`ifdef NANO_CPU_INCDEC_EN
    assign is_inc  = (op == 4'h8);
    assign is_dec  = (op == 4'h9);
`endif

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd;
        rf_wd = '0;
        pc_ld = 1'b0;
        unique case (1'b1)
            is_ld: begin
                rf_we = 1'b1;
                rf_wa = rn;
                rf_wd = dataR;
            end
            is_jmp:  pc_ld = 1'b1;
            is_brnz: pc_ld = |rf[rn];
            is_xor: begin
                rf_we = 1'b1;
                rf_wd = a ^ b;
            end
            is_sub: begin
                rf_we = 1'b1;
                rf_wd = a - b;
            end
            is_add: begin
                rf_we = 1'b1;
                rf_wd = a + b;
            end
            is_less: begin
                rf_we = 1'b1;
                rf_wd = {15'd0, (a < b)};
            end
`ifdef NANO_CPU_INCDEC_EN
            is_inc: begin
                rf_we = 1'b1;
                rf_wd = a + 16'd1;
            end
            is_dec: begin
                rf_we = 1'b1;
                rf_wd = a - 16'd1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        address  = pc;
        dataW    = '0;
        ce       = 1'b0;
        we       = 1'b0;
        unique case (state)
            FETCH: begin
                state_nx = DECODE;
                ce       = 1'b1;
            end
            DECODE: begin
                state_nx = EXECUTE;
                if (is_ld || is_st) begin
                    address = addr;
                    ce      = 1'b1;
                end
            end
            EXECUTE: begin
                state_nx = is_end ? HALT : FETCH;
                if (is_ld || is_st) begin
                    address = addr;
                    ce      = 1'b1;
                end
                if (is_st) begin
                    we    = 1'b1;
                    dataW = rf[rn];
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
        // keep the bus quiet while reset is held, whatever the state
        if (!rst) begin
            address = '0;
            dataW   = '0;
            ce      = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            rf    <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH) begin
                ir <= dataR;
                pc <= pc + 8'd1;
            end
            if (state == EXECUTE) begin
                if (pc_ld) pc <= addr;
                if (rf_we) rf[rf_wa] <= rf_wd;
            end
        end
    end
endmodule

// File: tb/tb_nano_cpu.sv
// tb_nano_cpu: directed and random programs checked against an
// instruction-level model of NanoCPU with its own memory image.
module tb_nano_cpu;
    logic        ck;
    logic        rst;
    logic [7:0]  address;
    logic [15:0] dataR;
    logic [15:0] dataW;
    logic        ce;
    logic        we;

    logic [15:0] mem [256];
    logic [15:0] mm  [256];
    logic [15:0] mr  [4];
    logic [7:0]  mpc;
    bit          mhalt;

    int checks;
    int failures;

    nano_cpu dut (
        .ck      (ck),
        .rst     (rst),
        .address (address),
        .dataR   (dataR),
        .dataW   (dataW),
        .ce      (ce),
        .we      (we)
    );

    assign dataR = mem[address];

    always @(posedge ck) if (we) mem[address] <= dataW;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [25:0] exp);
        logic [25:0] obs;
        #1;
        obs = {ce, we, address, dataW};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic chkv(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
            $error("%s", tag);
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] d);
        mem[a] = d;
        mm[a]  = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = '0;
        mpc   = '0;
        mhalt = 1'b0;
    endtask

    // one instruction (or one halted cycle); entered and left at a negedge
    task automatic step();
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  npc;
        logic [1:0]  r, rd, rs1, rs2;
        logic        ls, st;
        if (mhalt) begin
            chk("halt", {2'b00, mpc, 16'h0000});
            @(posedge ck);
            @(negedge ck);
            return;
        end
        ins = mm[mpc];
        op  = ins[15:12];
        a   = ins[11:4];
        r   = ins[1:0];
        rd  = ins[9:8];
        rs1 = ins[5:4];
        rs2 = ins[1:0];
        ls  = (op < 4'h2);
        st  = (op == 4'h1);
        npc = mpc + 8'd1;
        chk("fetch", {2'b10, mpc, 16'h0000});
        @(posedge ck);
        @(negedge ck);
        chk("decode", {ls, 1'b0, (ls ? a : npc), 16'h0000});
        @(posedge ck);
        @(negedge ck);
        chk("execute", {ls, st, (ls ? a : npc), (st ? mr[r] : 16'h0000)});
        @(posedge ck);
        case (op)
            4'h0: mr[r] = mm[a];
            4'h1: mm[a] = mr[r];
            4'h2: npc = a;
            4'h3: if (mr[r] != 16'h0) npc = a;
            4'h4: mr[rd] = mr[rs1] ^ mr[rs2];
            4'h5: mr[rd] = mr[rs1] - mr[rs2];
            4'h6: mr[rd] = mr[rs1] + mr[rs2];
            4'h7: mr[rd] = (mr[rs1] < mr[rs2]) ? 16'h1 : 16'h0;
`ifdef NANO_CPU_INCDEC_EN
            4'h8: mr[rd] = mr[rs1] + 16'h1;
            4'h9: mr[rd] = mr[rs1] - 16'h1;
`endif
            4'hF: mhalt = 1'b1;
            default: ;
        endcase
        mpc = npc;
        @(negedge ck);
    endtask

    task automatic mem_image(input string tag);
        int bad;
        bad = -1;
        for (int i = 255; i >= 0; i--) if (mem[i] !== mm[i]) bad = i;
        if (bad < 0) bad = 0;
        chkv(tag, mem[bad], mm[bad]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int i = 0; i < 256; i++) put(8'(i), 16'h0000);
        model_reset();

        // load / ALU / store / branch / INC-DEC / END
        put(8'h00, 16'h01E0); put(8'h01, 16'h01F1);
        put(8'h02, 16'h0202); put(8'h03, 16'h0213);
        put(8'h1E, 16'h1111); put(8'h1F, 16'h2222);
        put(8'h20, 16'h3333); put(8'h21, 16'h4444);
        put(8'h04, 16'h6003); put(8'h05, 16'h5101);
        put(8'h06, 16'h4300); put(8'h07, 16'h7210);
        put(8'h08, 16'h10F0); put(8'h09, 16'h1101);
        put(8'h0A, 16'h1112); put(8'h0B, 16'h3FF2);
        put(8'hFF, 16'h2140);
        put(8'h14, 16'h8000); put(8'h15, 16'h8110);
        put(8'h16, 16'h9220); put(8'h17, 16'h9330);
        put(8'h18, 16'h1400); put(8'h19, 16'h1411);
        put(8'h1A, 16'h1422); put(8'h1B, 16'h1433);
        put(8'h1C, 16'hF000);

        repeat (3) @(negedge ck);
        chk("reset_idle", 26'h0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chkv("brnz_taken", {8'h00, address}, 16'h00FF);
        step();
        chkv("jmp_target", {8'h00, address}, 16'h0014);
        for (int i = 0; i < 9; i++) step();
        chkv("st_r0", mem[8'h0F], 16'h5555);
        chkv("st_r1", mem[8'h10], 16'h3333);
        chkv("st_r2", mem[8'h11], 16'h0001);
`ifdef NANO_CPU_INCDEC_EN
        chkv("incdec_r0", mem[8'h40], 16'h5556);
        chkv("incdec_r1", mem[8'h41], 16'h3334);
        chkv("incdec_r2", mem[8'h42], 16'h0000);
        chkv("incdec_r3", mem[8'h43], 16'hFFFF);
`else
        chkv("nop8_r0", mem[8'h40], 16'h5555);
        chkv("nop8_r1", mem[8'h41], 16'h3333);
        chkv("nop9_r2", mem[8'h42], 16'h0001);
        chkv("nop9_r3", mem[8'h43], 16'h0000);
`endif
        for (int i = 0; i < 20; i++) step();
        mem_image("mem_dir1");

        // mid-run reset, fall-through branch, NOP, wrap at FF
        rst = 1'b0;
        chk("reset_midrun", 26'h0);
        model_reset();
        put(8'h00, 16'hA123); put(8'h01, 16'h3FF2);
        put(8'h02, 16'h0500); put(8'h03, 16'h8000);
        put(8'h04, 16'h1600); put(8'h05, 16'h2FF0);
        put(8'hFF, 16'h6000); put(8'h50, 16'h1234);
        @(negedge ck);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) step();
        chkv("brnz_fall", {8'h00, address}, 16'h0002);
        for (int i = 0; i < 5; i++) step();
        chkv("wrap_ff", {8'h00, address}, 16'h0000);
`ifdef NANO_CPU_INCDEC_EN
        chkv("inc_store", mem[8'h60], 16'h1235);
`else
        chkv("nop_store", mem[8'h60], 16'h1234);
`endif
        for (int i = 0; i < 4; i++) step();
        mem_image("mem_dir2");

        // random programs with a reset aborting an EXECUTE cycle
        for (int k = 0; k < 3; k++) begin
            rst = 1'b0;
            model_reset();
            for (int i = 0; i < 256; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
                put(8'(i), w);
            end
            @(negedge ck);
            rst = 1'b1;
            for (int i = 0; i < 40; i++) step();
            @(posedge ck);
            @(negedge ck);
            @(posedge ck);
            @(negedge ck);
            rst = 1'b0;
            chk("reset_abort", 26'h0);
            model_reset();
            @(negedge ck);
            rst = 1'b1;
            for (int i = 0; i < 60; i++) step();
            mem_image("mem_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
